// File: rtl/kar_ctrl_pkg.sv
// Shared control definitions for the time-shared Karatsuba multiplier arbiter:
// FSM encoding, id-width helper and default parameter values.
package kar_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } kar_state_e;

  localparam int KAR_DEF_N           = 10;
  localparam int KAR_DEF_REQS        = 4;
  localparam int KAR_DEF_CALC_CYCLES = 2;

  // Index width for n items, never narrower than one bit.
  function automatic int kar_idw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/Karatsuba_0.sv
// Generated single-level Karatsuba multiplier: full 2W-bit unsigned product.
// All arithmetic is carried modulo 2^(2W); the exact product always fits.
module Karatsuba_0 #(
  parameter int W = 10
) (
  input  logic [W-1:0]   input_0,
  input  logic [W-1:0]   input_1,
  output logic [2*W-1:0] output_2
);

  localparam int L  = (W + 1) / 2;
  localparam int H  = W - L;
  localparam int PW = 2 * W;

  logic [L-1:0]  a0, b0;
  logic [H-1:0]  a1, b1;
  logic [L:0]    sa, sb;
  logic [PW-1:0] z0, z1, z2, zm;

  assign a0 = input_0[L-1:0];
  assign a1 = input_0[W-1:L];
  assign b0 = input_1[L-1:0];
  assign b1 = input_1[W-1:L];

  assign sa = (L+1)'(a0) + (L+1)'(a1);
  assign sb = (L+1)'(b0) + (L+1)'(b1);

  assign z0 = PW'(a0) * PW'(b0);
  assign z2 = PW'(a1) * PW'(b1);
  assign zm = PW'(sa) * PW'(sb);
  assign z1 = zm - z0 - z2;

  assign output_2 = (z2 << (2 * L)) + (z1 << L) + z0;

endmodule

// File: rtl/kar_rr_arb.sv
// Round-robin one-hot grant: the first asserted request at or after ptr wins,
// wrapping modulo REQS.
module kar_rr_arb #(
  parameter int REQS = 4,
  parameter int PW   = 2
) (
  input  logic [REQS-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [REQS-1:0] grant
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < REQS; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= REQS) idx = idx - REQS;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/karatsuba_arbiter.sv
// Shares one combinational Karatsuba multiplier between REQS requesters:
// round-robin grant in IDLE, CALC_CYCLES of settle time, then a held response.
module karatsuba_arbiter
  import kar_ctrl_pkg::*;
#(
  parameter int N           = KAR_DEF_N,
  parameter int REQS        = KAR_DEF_REQS,
  parameter int CALC_CYCLES = KAR_DEF_CALC_CYCLES,
  localparam int IDW        = kar_idw(REQS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQS-1:0]   req_valid,
  output logic [REQS-1:0]   req_ready,
  input  logic [REQS*N-1:0] req_a,
  input  logic [REQS*N-1:0] req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [2*N-1:0]    resp_data,
  output logic              busy
);

  localparam int CW = kar_idw(CALC_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CALC_CYCLES - 1);
  localparam logic [IDW-1:0] ID_LAST  = IDW'(REQS - 1);

  kar_state_e     state, state_nxt;
  logic [IDW-1:0] ptr, gidx, id_q;
  logic [REQS-1:0] grant;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_q, b_q;
  logic [2*N-1:0] prod;
  logic           hs, calc_done;

  kar_rr_arb #(
    .REQS (REQS),
    .PW   (IDW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  // Fed only from the latched operands so the product is stable through CALC.
  Karatsuba_0 #(
    .W (N)
  ) u_mul (
    .input_0  (a_q),
    .input_1  (b_q),
    .output_2 (prod)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < REQS; i++)
      if (grant[i]) gidx = IDW'(i);
  end

  assign req_ready = (rst_n && state == IDLE) ? grant : '0;
  assign hs        = |(req_valid & req_ready);
  assign calc_done = (state == CALC) && (cnt == CNT_LAST);
  assign busy      = rst_n && (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = CALC;
      CALC:    if (calc_done) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr        <= '0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else begin
      if (hs) begin
        a_q  <= req_a[int'(gidx)*N +: N];
        b_q  <= req_b[int'(gidx)*N +: N];
        id_q <= gidx;
        ptr  <= (gidx == ID_LAST) ? '0 : gidx + 1'b1;
        cnt  <= '0;
      end
      if (state == CALC) cnt <= calc_done ? '0 : cnt + 1'b1;
      if (calc_done) begin
        resp_data  <= prod;
        resp_id    <= id_q;
        resp_valid <= 1'b1;
      end else if (resp_valid && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_karatsuba_arbiter.sv
// Bench for karatsuba_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed products, ids and grant orders.
module tb_karatsuba_arbiter;

  localparam int N    = 10;
  localparam int REQS = 4;
  localparam int C    = 2;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [REQS-1:0]   req_valid = '0;
  logic [REQS-1:0]   req_ready;
  logic [REQS*N-1:0] req_a = '0;
  logic [REQS*N-1:0] req_b = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b1;
  logic [IDW-1:0]    resp_id;
  logic [2*N-1:0]    resp_data;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  int     grants[$];
  int     resp_ids[$];
  longint resp_dat[$];

  karatsuba_arbiter #(.N(N), .REQS(REQS), .CALC_CYCLES(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Round-robin rule: first valid requester at or after p, wrapping.
  function automatic int pick(logic [REQS-1:0] v, int p);
    for (int k = 0; k < REQS; k++)
      if (v[(p + k) % REQS]) return (p + k) % REQS;
    return -1;
  endfunction

  // Transaction model: idle / busy-for-C-cycles / response-held.
  bit     m_idle = 1;
  int     m_left = 0;
  bit     m_rv   = 0;
  longint m_data = 0;
  longint m_prod = 0;
  int     m_id   = 0;
  int     m_idp  = 0;
  int     m_ptr  = 0;

  always @(posedge clk) begin
    int g;
    if (rst_n && resp_valid && resp_ready) begin
      resp_ids.push_back(int'(resp_id));
      resp_dat.push_back(longint'(resp_data));
    end
    if (rst_n)
      for (int i = 0; i < REQS; i++)
        if (req_valid[i] && req_ready[i]) grants.push_back(i);

    if (!rst_n) begin
      m_idle = 1; m_left = 0; m_rv = 0; m_data = 0; m_id = 0; m_ptr = 0;
    end else if (m_idle) begin
      g = pick(req_valid, m_ptr);
      if (g >= 0) begin
        m_idle = 0;
        m_left = C;
        m_idp  = g;
        m_prod = longint'(req_a[g*N +: N]) * longint'(req_b[g*N +: N]);
        m_ptr  = (g + 1) % REQS;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_rv = 1; m_data = m_prod; m_id = m_idp;
      end
    end else if (resp_ready) begin
      m_rv = 0; m_idle = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [REQS-1:0] er;
      int g;
      er = '0;
      if (rst_n && m_idle) begin
        g = pick(req_valid, m_ptr);
        if (g >= 0) er[g] = 1'b1;
      end
      chk("req_ready", req_ready, er);
      chk("busy", busy, rst_n && !m_idle);
      chk("resp_valid", resp_valid, m_rv);
      chk("resp_data", resp_data, m_data);
      chk("resp_id", resp_id, m_id);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_req(int i, int a, int b);
    req_a[i*N +: N] = N'(a);
    req_b[i*N +: N] = N'(b);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic grant_one(int i, int a, int b, output int hs_cyc);
    set_req(i, a, b);
    req_valid[i] = 1'b1;
    hs_cyc = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        tick();
        hs_cyc = cyc;
        break;
      end
    end
    req_valid[i] = 1'b0;
    if (hs_cyc < 0) timeout("grant_wait");
  endtask

  task automatic wait_rv(output int c);
    c = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (resp_valid) begin c = cyc; break; end
    end
    if (c < 0) timeout("resp_wait");
  endtask

  task automatic drain(bit rnd);
    bit done;
    done = 0;
    for (int k = 0; k < 200; k++) begin
      if (!busy && !resp_valid) begin done = 1; break; end
      resp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    resp_ready = 1'b1;
    if (!done) timeout("drain");
  endtask

  // Drop each requester's valid right after its handshake until none remain.
  task automatic serve_all();
    bit done;
    done = 0;
    for (int k = 0; k < 300; k++) begin
      if (req_valid == '0) begin done = 1; break; end
      @(negedge clk);
      if (|(req_valid & req_ready)) begin
        logic [REQS-1:0] hit;
        hit = req_valid & req_ready;
        tick();
        req_valid = req_valid & ~hit;
      end else begin
        tick();
      end
    end
    if (!done) timeout("serve_all");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, rc, g0, r0;
    int exp37 [4] = '{3, 6, 9, 12};

    // Reset state
    @(posedge clk); #1;
    chk_en = 1;
    tick();
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Max operands on requester 0, latency pinned
    grant_one(0, 1023, 1023, hs);
    wait_rv(rc);
    chk("t36_latency", rc - hs, C);
    chk("t36_data_live", resp_data, 1046529);
    drain(0);
    chk("t36_data", resp_dat[$], 1046529);
    chk("t36_id", resp_ids[$], 0);

    // All four at once from a fresh pointer
    do_reset(1);
    for (int i = 0; i < REQS; i++) set_req(i, i + 1, 3);
    g0 = grants.size();
    r0 = resp_dat.size();
    req_valid = 4'hF;
    serve_all();
    drain(0);
    for (int k = 0; k < 4; k++) begin
      chk("t37_grant", grants[g0 + k], k);
      chk("t37_id", resp_ids[r0 + k], k);
      chk("t37_data", resp_dat[r0 + k], exp37[k]);
    end

    // Backpressure holds the response and blocks new grants
    resp_ready = 1'b0;
    grant_one(2, 5, 7, hs);
    wait_rv(rc);
    set_req(0, 2, 2);
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t38_valid", resp_valid, 1);
      chk("t38_data", resp_data, 35);
      chk("t38_id", resp_id, 2);
      chk("t38_ready", req_ready, 0);
      chk("t38_busy", busy, 1);
      tick();
    end
    resp_ready = 1'b1;
    serve_all();
    drain(0);
    chk("t38_next_data", resp_dat[$], 4);
    chk("t38_next_id", resp_ids[$], 0);

    // Two persistent requesters alternate
    do_reset(1);
    set_req(1, 11, 13);
    set_req(3, 17, 19);
    g0 = grants.size();
    req_valid = 4'b1010;
    rc = 0;
    for (int k = 0; k < 500; k++) begin
      if (grants.size() >= g0 + 8) begin rc = 1; break; end
      tick();
    end
    req_valid = '0;
    if (rc == 0) timeout("t39_grants");
    drain(0);
    for (int k = 0; k < 8; k++)
      chk("t39_grant", grants[g0 + k], (k % 2 == 0) ? 1 : 3);
    chk("t39_data", resp_dat[$], 17 * 19);

    // Reset mid-CALC aborts silently and clears the pointer
    do_reset(1);
    r0 = resp_dat.size();
    grant_one(0, 9, 9, hs);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t40_noresp", resp_dat.size(), r0);
    chk("t40_busy", busy, 0);
    g0 = grants.size();
    grant_one(2, 4, 6, hs);
    drain(0);
    chk("t40_grant2", grants[g0], 2);
    chk("t40_data", resp_dat[$], 24);
    set_req(0, 1, 1);
    set_req(3, 2, 2);
    req_valid = 4'b1001;
    serve_all();
    drain(0);
    chk("t40_ptr3", grants[g0 + 1], 3);
    chk("t40_then0", grants[g0 + 2], 0);

    // Random operands over random requesters with random backpressure
    r0 = resp_dat.size();
    for (int k = 0; k < 200; k++) begin
      grant_one($urandom_range(0, REQS - 1), $urandom_range(0, 1023),
                $urandom_range(0, 1023), hs);
      drain(1);
    end
    chk("t41_count", resp_dat.size() - r0, 200);
    grant_one(1, 0, 777, hs);
    drain(0);
    chk("t41_zero", resp_dat[$], 0);
    chk("t41_zero_id", resp_ids[$], 1);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
